decoder_iq: RTL
===============

# decoder_iq

Parametrised decode stage with a built-in instruction queue, sitting between instruction fetch and ROB/RS/LSB dispatch. Fetched instructions are buffered in a circular queue of 2**QA_W entries, and fetch is decoupled from ROB back-pressure. Each cycle the block pops and decodes at most one RV32I instruction into registered dispatch fields. It flushes on misprediction and flags illegal encodings instead of silently dropping them.

## Interface
- QA_W, 3, queue address width; DEPTH = 2**QA_W entries (QA_W ≥ 1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- jp_wrong  in  1  misprediction flush, sampled at clock edge
- ins_flag  in  1  fetch delivers an instruction this cycle
- ins  in  32  instruction word
- pc  in  32  instruction address
- jp_flag  in  1  predictor: taken
- jp_pc  in  32  predicted target
- stall_IF  out  1  queue almost full; fetch must not issue
- ROB_full  in  1  dispatch back-pressure
- ins_flag_ROB  out  1  decoded instruction valid (one-cycle pulse)
- ins_flag_RS  out  1  instruction goes to RS
- ins_flag_LSB  out  1  instruction goes to LSB
- illegal  out  1  undecodable instruction
- rs1, rs2, rd  out  5 each  register indices (0 = unused)
- insty  out  6  operation code, from the shared defines
- insty_LSB  out  3  insty[2:0], combinational
- imm  out  32  decoded immediate
- pc_ROB, jp_pc_ROB  out  32 each  instruction pc, predicted target
- jp_flag_ROB  out  1  predicted taken

## Operation
- Queue entry holds {ins, pc, jp_flag, jp_pc}; head/tail are QA_W bits and wrap modulo DEPTH; count is QA_W+1 bits.
- Push fires when rdy && !jp_wrong && ins_flag && (count < DEPTH || pop). A push arriving with count == DEPTH and no pop is dropped; fetch is required to honour stall_IF.
- Pop fires when rdy && !jp_wrong && !ROB_full && count > 0. An entry written in cycle t is poppable from cycle t+1; there is no bypass.
- stall_IF = (count ≥ DEPTH−1), combinational from count. This absorbs the one instruction already in flight from fetch.
- On pop, register outputs from the head entry and pulse ins_flag_ROB = 1. In a cycle without pop, all three flags and illegal = 0; the data fields hold their values.
- Field rules:
  - rd = 0 for branch (99) and store (35).
  - rs1 = 0 for JAL (111), LUI (55), AUIPC (23).
  - rs2 = ins[24:20] only for branch, store and OP (51); otherwise 0.
- Immediates:
  - Load, OP-IMM, JALR: sign-extended I-type, except SLLI/SRLI/SRAI, which take zero-extended shamt ins[24:20].
  - Store: S-type.
  - Branch: B-type, bit 0 = 0.
  - JAL: J-type.
  - LUI/AUIPC: ins[31:12] << 12.
- Routing:
  - ins_flag_LSB = load/store.
  - ins_flag_RS = OP, OP-IMM, branch, JALR.
  - LUI/AUIPC/JAL go to ROB only.
- Illegal: unknown opcode, unlisted funct3 (load 3/6/7, store ≥3, branch 2/3), or ins[30] set where not SUB/SRA/SRAI.
  - Response: insty = 0, rd = rs1 = rs2 = 0, RS/LSB flags 0, ins_flag_ROB = 1, illegal = 1.

## Timing
- Reset (async): head = tail = count = 0. All outputs 0, including stall_IF = 0 and imm = 0.
- Latency: ins_flag in cycle t with queue empty and ROB_full low gives ins_flag_ROB high in cycle t+2.
- Throughput: one instruction per cycle sustained.
- jp_wrong: at that edge head = tail = count = 0, all flags cleared, same-cycle push and pop discarded. Takes priority over everything except rst.
- !rdy: queue and all outputs hold, including flags.
- Simultaneous push and pop at count == DEPTH: both occur and count is unchanged.
- Reset asserted mid-stream: every queued entry is discarded immediately.

## Test plan
- Reset, then push 0xFFF00293 (addi x5,x0,-1) → 2 cycles later ins_flag_ROB = ins_flag_RS = 1, rd = 5, rs1 = 0, rs2 = 0, imm = 0xFFFFFFFF, insty = ADDI.
- Push 0x40315093 (srai x1,x2,3) then 0x00312423 (sw x3,8(x2)) back-to-back:
  - srai → insty = SRAI, imm = 3.
  - sw → rd = 0, rs1 = 2, rs2 = 3, imm = 8, ins_flag_LSB = 1, insty_LSB = SW[2:0].
- DEPTH = 8 with ROB_full = 1, push every cycle → stall_IF rises when count reaches 7, an 8th push is accepted, a 9th is dropped. Release ROB_full → 8 pulses in order with matching pc_ROB.
- Queue holding 5 entries plus a push, assert jp_wrong → no ins_flag_ROB next cycle, count = 0, stall_IF = 0. A new push decodes normally.
- Push 0x0000007F, then 0x00003003 (load funct3 = 3) → both give ins_flag_ROB = 1, illegal = 1, insty = 0, RS/LSB flags 0.
- Push 3 entries, toggle rdy low for 4 cycles mid-pop, then assert rst asynchronously → outputs hold while rdy is low. On rst, all outputs go to 0 with no clock edge, and nothing is popped after release.

Source files
------------

// File: rtl/decoder_iq_if.sv
// Fetch / dispatch bundle for the decode stage with instruction queue.
// slave: the decoder's view. master: the surrounding pipeline's view.
interface decoder_iq_if;
  logic        rdy;
  logic        jp_wrong;
  logic        ins_flag;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        jp_flag;
  logic [31:0] jp_pc;
  logic        stall_IF;
  logic        ROB_full;
  logic        ins_flag_ROB;
  logic        ins_flag_RS;
  logic        ins_flag_LSB;
  logic        illegal;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [5:0]  insty;
  logic [2:0]  insty_LSB;
  logic [31:0] imm;
  logic [31:0] pc_ROB;
  logic [31:0] jp_pc_ROB;
  logic        jp_flag_ROB;

  modport slave (
    input  rdy, jp_wrong, ins_flag, ins, pc, jp_flag, jp_pc, ROB_full,
    output stall_IF, ins_flag_ROB, ins_flag_RS, ins_flag_LSB, illegal,
           rs1, rs2, rd, insty, insty_LSB, imm, pc_ROB, jp_pc_ROB, jp_flag_ROB
  );

  modport master (
    output rdy, jp_wrong, ins_flag, ins, pc, jp_flag, jp_pc, ROB_full,
    input  stall_IF, ins_flag_ROB, ins_flag_RS, ins_flag_LSB, illegal,
           rs1, rs2, rd, insty, insty_LSB, imm, pc_ROB, jp_pc_ROB, jp_flag_ROB
  );
endinterface

// File: rtl/decoder_iq.sv
// RV32I decode stage with a circular instruction queue of 2**QA_W entries.
// Pops and decodes at most one instruction per cycle into registered
// dispatch fields; flushes on misprediction; flags illegal encodings.
// insty encoding groups: loads 8+funct3, stores 16+funct3, branches
// 24+funct3, OP-IMM 32+funct3, OP 48+funct3, ins[30] adds 8 (SUB/SRA/SRAI).
module decoder_iq #(
  parameter int unsigned QA_W = 3
) (
  input logic         clk,
  input logic         rst,
  decoder_iq_if.slave bus
);
  localparam int unsigned DEPTH = 1 << QA_W;
  localparam logic [QA_W:0] FULL   = {1'b1, {QA_W{1'b0}}};
  localparam logic [QA_W:0] ALMOST = {1'b0, {QA_W{1'b1}}};

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OPIMM  = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_e;

  typedef enum logic [5:0] {
    I_NONE  = 6'd0,  I_LUI   = 6'd1,  I_AUIPC = 6'd2,  I_JAL   = 6'd3,
    I_JALR  = 6'd4,
    I_LB    = 6'd8,  I_LH    = 6'd9,  I_LW    = 6'd10, I_LBU   = 6'd12,
    I_LHU   = 6'd13,
    I_SB    = 6'd16, I_SH    = 6'd17, I_SW    = 6'd18,
    I_BEQ   = 6'd24, I_BNE   = 6'd25, I_BLT   = 6'd28, I_BGE   = 6'd29,
    I_BLTU  = 6'd30, I_BGEU  = 6'd31,
    I_ADDI  = 6'd32, I_SLLI  = 6'd33, I_SLTI  = 6'd34, I_SLTIU = 6'd35,
    I_XORI  = 6'd36, I_SRLI  = 6'd37, I_ORI   = 6'd38, I_ANDI  = 6'd39,
    I_SRAI  = 6'd45,
    I_ADD   = 6'd48, I_SLL   = 6'd49, I_SLT   = 6'd50, I_SLTU  = 6'd51,
    I_XOR   = 6'd52, I_SRL   = 6'd53, I_OR    = 6'd54, I_AND   = 6'd55,
    I_SUB   = 6'd56, I_SRA   = 6'd61
  } insty_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        jp_flag;
    logic [31:0] jp_pc;
  } entry_t;

  entry_t          mem [0:DEPTH-1];
  logic [QA_W-1:0] head;
  logic [QA_W-1:0] tail;
  logic [QA_W:0]   count;
  logic            push;
  logic            pop;

  entry_t      h;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  insty_e      d_insty;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;
  logic        d_rs, d_lsb, d_ill;

  logic        q_flag_rob, q_flag_rs, q_flag_lsb, q_ill, q_jp_flag;
  logic [4:0]  q_rd, q_rs1, q_rs2;
  insty_e      q_insty;
  logic [31:0] q_imm, q_pc, q_jp_pc;

  // A push may land on a full queue only when the head leaves the same cycle.
  assign pop  = bus.rdy && !bus.jp_wrong && !bus.ROB_full && (count != '0);
  assign push = bus.rdy && !bus.jp_wrong && bus.ins_flag && ((count < FULL) || pop);

  assign bus.stall_IF = (count >= ALMOST);

  // Queue pointers and occupancy; misprediction empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.rdy) begin
      if (bus.jp_wrong) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + QA_W'(1);
        if (pop)  head <= head + QA_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (QA_W+1)'(1);
          2'b01:   count <= count - (QA_W+1)'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage; entries become visible to the head one cycle after writing.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{ins: bus.ins, pc: bus.pc, jp_flag: bus.jp_flag, jp_pc: bus.jp_pc};
  end

  assign h     = mem[head];
  assign f3    = h.ins[14:12];
  assign imm_i = {{20{h.ins[31]}}, h.ins[31:20]};

  // Decode of the head entry; illegal encodings collapse to a bare ROB entry.
  always_comb begin
    d_insty = I_NONE;
    d_rd    = h.ins[11:7];
    d_rs1   = h.ins[19:15];
    d_rs2   = '0;
    d_imm   = '0;
    d_rs    = 1'b0;
    d_lsb   = 1'b0;
    d_ill   = 1'b0;
    case (opcode_e'(h.ins[6:0]))
      OPC_LUI: begin
        d_insty = I_LUI;
        d_rs1   = '0;
        d_imm   = {h.ins[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d_insty = I_AUIPC;
        d_rs1   = '0;
        d_imm   = {h.ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        d_insty = I_JAL;
        d_rs1   = '0;
        d_imm   = {{12{h.ins[31]}}, h.ins[19:12], h.ins[20], h.ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        d_insty = I_JALR;
        d_imm   = imm_i;
        d_rs    = 1'b1;
      end
      OPC_BRANCH: begin
        d_rd  = '0;
        d_rs2 = h.ins[24:20];
        d_imm = {{20{h.ins[31]}}, h.ins[7], h.ins[30:25], h.ins[11:8], 1'b0};
        d_rs  = 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) d_ill = 1'b1;
        else d_insty = insty_e'({3'b011, f3});
      end
      OPC_LOAD: begin
        d_imm = imm_i;
        d_lsb = 1'b1;
        if (f3 == 3'd3 || f3 >= 3'd6) d_ill = 1'b1;
        else d_insty = insty_e'({3'b001, f3});
      end
      OPC_STORE: begin
        d_rd  = '0;
        d_rs2 = h.ins[24:20];
        d_imm = {{20{h.ins[31]}}, h.ins[31:25], h.ins[11:7]};
        d_lsb = 1'b1;
        if (f3 >= 3'd3) d_ill = 1'b1;
        else d_insty = insty_e'({3'b010, f3});
      end
      OPC_OPIMM: begin
        d_rs = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          d_imm = {27'b0, h.ins[24:20]};
          if (f3 == 3'd1 && h.ins[30]) d_ill = 1'b1;
          else d_insty = insty_e'({2'b10, h.ins[30], f3});
        end else begin
          d_imm   = imm_i;
          d_insty = insty_e'({3'b100, f3});
        end
      end
      OPC_OP: begin
        d_rs2 = h.ins[24:20];
        d_rs  = 1'b1;
        if (h.ins[30] && f3 != 3'd0 && f3 != 3'd5) d_ill = 1'b1;
        else d_insty = insty_e'({2'b11, h.ins[30], f3});
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_insty = I_NONE;
      d_rd    = '0;
      d_rs1   = '0;
      d_rs2   = '0;
      d_imm   = '0;
      d_rs    = 1'b0;
      d_lsb   = 1'b0;
    end
  end

  // Dispatch registers: flags pulse on pop, data fields hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_flag_rob <= 1'b0;
      q_flag_rs  <= 1'b0;
      q_flag_lsb <= 1'b0;
      q_ill      <= 1'b0;
      q_rd       <= '0;
      q_rs1      <= '0;
      q_rs2      <= '0;
      q_insty    <= I_NONE;
      q_imm      <= '0;
      q_pc       <= '0;
      q_jp_pc    <= '0;
      q_jp_flag  <= 1'b0;
    end else if (bus.rdy) begin
      if (pop) begin
        q_flag_rob <= 1'b1;
        q_flag_rs  <= d_rs;
        q_flag_lsb <= d_lsb;
        q_ill      <= d_ill;
        q_rd       <= d_rd;
        q_rs1      <= d_rs1;
        q_rs2      <= d_rs2;
        q_insty    <= d_insty;
        q_imm      <= d_imm;
        q_pc       <= h.pc;
        q_jp_pc    <= h.jp_pc;
        q_jp_flag  <= h.jp_flag;
      end else begin
        q_flag_rob <= 1'b0;
        q_flag_rs  <= 1'b0;
        q_flag_lsb <= 1'b0;
        q_ill      <= 1'b0;
      end
    end
  end

  assign bus.ins_flag_ROB = q_flag_rob;
  assign bus.ins_flag_RS  = q_flag_rs;
  assign bus.ins_flag_LSB = q_flag_lsb;
  assign bus.illegal      = q_ill;
  assign bus.rd           = q_rd;
  assign bus.rs1          = q_rs1;
  assign bus.rs2          = q_rs2;
  assign bus.insty        = q_insty;
  assign bus.insty_LSB    = q_insty[2:0];
  assign bus.imm          = q_imm;
  assign bus.pc_ROB       = q_pc;
  assign bus.jp_pc_ROB    = q_jp_pc;
  assign bus.jp_flag_ROB  = q_jp_flag;
endmodule
